// File: rtl/crc_frame_serializer_if.sv
// crc_frame_serializer_if: valid/ready word stream feeding crc_frame_serializer.
//   in_valid / in_data / in_last : driven by the word source (master)
//   in_ready                     : driven by the serializer (slave)
interface crc_frame_serializer_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: takes parallel words over a valid/ready stream and
// shifts them out MSB-first on a 1-bit line, steering a downstream serial
// CRC stage (seed once per frame, one enable per data bit).
//
// Optional feature macro: CRC_FRAME_APPEND_EN
//   defined   : after the last data bit, one cycle to capture crc_in, then
//               CRC_W CRC bits MSB-first (crc_enable low), ser_last on final CRC bit.
//   undefined : crc_in unused, ser_last on the final bit of the last word.
//
// Ports
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   in_s        : word stream (in_valid/in_ready/in_data/in_last), slave side
//   crc_in      : CRC stage crc_out
//   crc_enable  : CRC stage enable (high for every data bit)
//   crc_init    : CRC stage init (one cycle at frame start)
//   crc_data    : CRC stage data_in (equals ser_bit while crc_enable)
//   ser_valid   : ser_bit valid this cycle
//   ser_bit     : serial output bit
//   ser_last    : final bit of the frame
//   busy        : frame open (first word accepted, final bit not yet sent)
module crc_frame_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CRC_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  crc_frame_serializer_if.slave in_s,
  input  logic [CRC_W-1:0]     crc_in,
  output logic                 crc_enable,
  output logic                 crc_init,
  output logic                 crc_data,
  output logic                 ser_valid,
  output logic                 ser_bit,
  output logic                 ser_last,
  output logic                 busy
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_SHIFT  = 2'd2,
    S_APPEND = 2'd3
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               word_last;
  logic               frame_open;

  logic               ready_c;
  logic               accept_c;
  logic               last_bit_c;

`ifdef CRC_FRAME_APPEND_EN
  localparam int unsigned CRC_CNT_W = (CRC_W > 2) ? $clog2(CRC_W) : 1;

  logic [CRC_W-1:0]     crc_sh;
  logic [CRC_CNT_W-1:0] crc_cnt;
  logic                 crc_loaded;
`else
  logic unused_crc_in;
  assign unused_crc_in = ^crc_in;
`endif

  // Ready in IDLE, or on the final bit of a non-last word so the next word
  // can be loaded without a bubble. Forced low while reset is held.
  assign last_bit_c  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign ready_c     = ~reset & ((state == S_IDLE) |
                                 ((state == S_SHIFT) & last_bit_c & ~word_last));
  assign in_s.in_ready = ready_c;
  assign accept_c    = in_s.in_valid & ready_c;

  // Frame FSM; every output register holds the value for the cycle that
  // follows the transition that sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_last  <= 1'b0;
      frame_open <= 1'b0;
      crc_enable <= 1'b0;
      crc_init   <= 1'b0;
      crc_data   <= 1'b0;
      ser_valid  <= 1'b0;
      ser_bit    <= 1'b0;
      ser_last   <= 1'b0;
      busy       <= 1'b0;
`ifdef CRC_FRAME_APPEND_EN
      crc_sh     <= '0;
      crc_cnt    <= '0;
      crc_loaded <= 1'b0;
`endif
    end else begin
      crc_init   <= 1'b0;
      crc_enable <= 1'b0;
      crc_data   <= 1'b0;
      ser_valid  <= 1'b0;
      ser_bit    <= 1'b0;
      ser_last   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept_c) begin
            shreg     <= in_s.in_data;
            word_last <= in_s.in_last;
            bit_cnt   <= '0;
            if (frame_open) begin
              // Resuming a stalled frame: first bit goes out next cycle, no reseed.
              state      <= S_SHIFT;
              ser_valid  <= 1'b1;
              ser_bit    <= in_s.in_data[DATA_W-1];
              crc_enable <= 1'b1;
              crc_data   <= in_s.in_data[DATA_W-1];
            end else begin
              state      <= S_INIT;
              crc_init   <= 1'b1;
              frame_open <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end

        S_INIT: begin
          state      <= S_SHIFT;
          ser_valid  <= 1'b1;
          ser_bit    <= shreg[DATA_W-1];
          crc_enable <= 1'b1;
          crc_data   <= shreg[DATA_W-1];
        end

        S_SHIFT: begin
          if (!last_bit_c) begin
            shreg      <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt    <= bit_cnt + CNT_W'(1);
            ser_valid  <= 1'b1;
            ser_bit    <= shreg[DATA_W-2];
            crc_enable <= 1'b1;
            crc_data   <= shreg[DATA_W-2];
`ifndef CRC_FRAME_APPEND_EN
            ser_last   <= word_last & (bit_cnt == CNT_W'(DATA_W - 2));
`endif
          end else if (word_last) begin
`ifdef CRC_FRAME_APPEND_EN
            state      <= S_APPEND;
            crc_cnt    <= '0;
            crc_loaded <= 1'b0;
`else
            state      <= S_IDLE;
            frame_open <= 1'b0;
            busy       <= 1'b0;
`endif
          end else if (accept_c) begin
            shreg      <= in_s.in_data;
            word_last  <= in_s.in_last;
            bit_cnt    <= '0;
            ser_valid  <= 1'b1;
            ser_bit    <= in_s.in_data[DATA_W-1];
            crc_enable <= 1'b1;
            crc_data   <= in_s.in_data[DATA_W-1];
          end else begin
            // Source stalled mid-frame: frame and busy stay open.
            state <= S_IDLE;
          end
        end

`ifdef CRC_FRAME_APPEND_EN
        S_APPEND: begin
          if (!crc_loaded) begin
            // CRC stage has absorbed the last data bit by now.
            crc_loaded <= 1'b1;
            crc_sh     <= {crc_in[CRC_W-2:0], 1'b0};
            ser_valid  <= 1'b1;
            ser_bit    <= crc_in[CRC_W-1];
          end else if (crc_cnt != CRC_CNT_W'(CRC_W - 1)) begin
            crc_sh    <= {crc_sh[CRC_W-2:0], 1'b0};
            crc_cnt   <= crc_cnt + CRC_CNT_W'(1);
            ser_valid <= 1'b1;
            ser_bit   <= crc_sh[CRC_W-1];
            ser_last  <= (crc_cnt == CRC_CNT_W'(CRC_W - 2));
          end else begin
            state      <= S_IDLE;
            frame_open <= 1'b0;
            busy       <= 1'b0;
            crc_loaded <= 1'b0;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Self-checking bench for crc_frame_serializer with a behavioural serial
// CRC-CCITT stage (seed 0xFFFF, poly 0x1021, MSB-first) closing the loop.
module tb_crc_frame_serializer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CRC_W  = 16;
`ifdef CRC_FRAME_APPEND_EN
  localparam int unsigned APP_BITS = 16;
`else
  localparam int unsigned APP_BITS = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CRC_W-1:0]  crc_in;
  logic              crc_enable, crc_init, crc_data;
  logic              ser_valid, ser_bit, ser_last, busy;

  crc_frame_serializer_if #(.DATA_W(DATA_W)) in_if ();

  crc_frame_serializer #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_s       (in_if),
    .crc_in     (crc_in),
    .crc_enable (crc_enable),
    .crc_init   (crc_init),
    .crc_data   (crc_data),
    .ser_valid  (ser_valid),
    .ser_bit    (ser_bit),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream serial CRC stage model
  logic [15:0] crc_reg;
  always @(posedge clk or posedge reset) begin
    if (reset)           crc_reg <= 16'hFFFF;
    else if (crc_init)   crc_reg <= 16'hFFFF;
    else if (crc_enable) crc_reg <= {crc_reg[14:0], 1'b0} ^ ((crc_reg[15] ^ crc_data) ? 16'h1021 : 16'h0000);
  end
  assign crc_in = crc_reg;

  // Output monitor (negedge sampling)
  int unsigned cyc = 0;
  bit          bits_q[$];
  bit          last_fq[$];
  bit          en_q[$];
  bit          rdy_q[$];
  int unsigned cyc_q[$];
  int unsigned init_cnt = 0, init_cyc = 0, last_cnt = 0;
  int unsigned busy_err = 0, stray_last = 0, data_err = 0;
  bit          mon_open = 1'b0, after_last = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_open   = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last && busy) busy_err++;
      after_last = 1'b0;
      if (crc_init) begin
        init_cnt++;
        init_cyc = cyc;
        mon_open = 1'b1;
      end
      if (mon_open && !busy) busy_err++;
      if (ser_valid) begin
        bits_q.push_back(ser_bit);
        last_fq.push_back(ser_last);
        en_q.push_back(crc_enable);
        rdy_q.push_back(in_if.in_ready);
        cyc_q.push_back(cyc);
        if (crc_enable ? (crc_data !== ser_bit) : (crc_data !== 1'b0)) data_err++;
      end else if (ser_last) begin
        stray_last++;
      end
      if (ser_last) begin
        last_cnt++;
        mon_open   = 1'b0;
        after_last = 1'b1;
      end
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [8:0][7:0] w, input int unsigned n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int unsigned i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ w[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  typedef struct {
    logic [8:0][7:0] w;
    int unsigned     n;
    int unsigned     gap;       // posedges with in_valid low before word 1
    bit              toggle;    // toggle in_valid while in_ready is low
    int unsigned     exp_step;  // cycles from bit 7 to bit 8
    bit              fixed;
    logic [15:0]     fixed_crc;
  } frame_t;

  frame_t frames[5];

  // Present one word; returns ok=0 if never accepted within budget.
  task automatic send_word(input logic [7:0] d, input logic l, input bit tog, output bit ok);
    int unsigned budget;
    bit          done;
    budget = 0;
    done   = 1'b0;
    ok     = 1'b0;
    in_if.in_data  = d;
    in_if.in_last  = l;
    in_if.in_valid = 1'b1;
    while (!done && budget < 200) begin
      @(negedge clk);
      if (in_if.in_ready) begin
        in_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ok   = 1'b1;
        done = 1'b1;
      end else if (tog) begin
        in_if.in_valid = ~in_if.in_valid;
      end
      budget++;
    end
  endtask

  task automatic run_frame(input int idx, input frame_t f);
    int unsigned base, b_init, b_last, b_busy, b_stray, b_data;
    int unsigned exp_len, got_len, mism, en_mis, rdy_mis, last_n, last_pos, nd, budget;
    logic [15:0] exp_crc, got_crc;
    bit          ok, expb;
    base    = bits_q.size();
    b_init  = init_cnt;
    b_last  = last_cnt;
    b_busy  = busy_err;
    b_stray = stray_last;
    b_data  = data_err;
    nd      = 8 * f.n;
    exp_len = nd + APP_BITS;
    exp_crc = f.fixed ? f.fixed_crc : crc_ref(f.w, f.n);

    for (int unsigned i = 0; i < f.n; i++) begin
      if (i == 1 && f.gap != 0) begin
        in_if.in_valid = 1'b0;
        repeat (f.gap) @(posedge clk);
        #1;
      end
      send_word(f.w[i], (i == f.n - 1), f.toggle, ok);
      if (!ok) check($sformatf("f%0d_accept_w%0d", idx, i), 32'(ok), 32'd1);
    end
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;

    budget = 0;
    while (last_cnt == b_last && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    check($sformatf("f%0d_ser_last_seen", idx), 32'(last_cnt - b_last), 32'd1);
    repeat (20) @(posedge clk);
    #1;

    got_len = bits_q.size() - base;
    check($sformatf("f%0d_len", idx), got_len, exp_len);
    check($sformatf("f%0d_crc_init_count", idx), init_cnt - b_init, 32'd1);
    check($sformatf("f%0d_busy_errors", idx), busy_err - b_busy, 32'd0);
    check($sformatf("f%0d_crc_data_errors", idx), (data_err - b_data) + (stray_last - b_stray), 32'd0);

    if (got_len >= exp_len) begin
      mism = 0; en_mis = 0; rdy_mis = 0; last_n = 0; last_pos = 0;
      for (int unsigned i = 0; i < exp_len; i++) begin
        if (i < nd) expb = f.w[i / 8][7 - (i % 8)];
        else        expb = exp_crc[15 - (i - nd)];
        if (bits_q[base + i] != expb) mism++;
        if (en_q[base + i] != (i < nd)) en_mis++;
        if (rdy_q[base + i] != ((i < nd) && (i % 8 == 7) && (i / 8 < f.n - 1))) rdy_mis++;
        if (last_fq[base + i]) begin
          last_n++;
          last_pos = i;
        end
      end
      check($sformatf("f%0d_bit_errors", idx), mism, 32'd0);
      check($sformatf("f%0d_crc_enable_errors", idx), en_mis, 32'd0);
      check($sformatf("f%0d_in_ready_errors", idx), rdy_mis, 32'd0);
      check($sformatf("f%0d_ser_last_pos", idx), {last_n[15:0], last_pos[15:0]}, {16'd1, 16'(exp_len - 1)});
      check($sformatf("f%0d_init_to_bit0", idx), cyc_q[base] - init_cyc, 32'd1);
      check($sformatf("f%0d_data_span", idx), cyc_q[base + nd - 1] - cyc_q[base],
            (nd - 1) + ((f.n > 1) ? (f.exp_step - 1) : 0));
      if (f.n > 1)
        check($sformatf("f%0d_word1_step", idx), cyc_q[base + 8] - cyc_q[base + 7], f.exp_step);
`ifdef CRC_FRAME_APPEND_EN
      got_crc = '0;
      for (int unsigned i = 0; i < 16; i++) got_crc = {got_crc[14:0], bits_q[base + nd + i]};
      check($sformatf("f%0d_crc", idx), 32'(got_crc), 32'(exp_crc));
      check($sformatf("f%0d_append_gap", idx), cyc_q[base + nd] - cyc_q[base + nd - 1], 32'd2);
`else
      got_crc = exp_crc;
`endif
    end
  endtask

  logic [8:0][7:0] digits;
  int unsigned     seen;
  int unsigned     budget;

  initial begin
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;

    for (int unsigned i = 0; i < 9; i++) digits[i] = 8'(32'h31 + i);

    // 0: "123456789" back-to-back
    frames[0] = '{w: digits, n: 9, gap: 0, toggle: 1'b0, exp_step: 1, fixed: 1'b1, fixed_crc: 16'h29B1};
    // 1: A5,3C,FF with in_valid held
    frames[1] = '{w: '0, n: 3, gap: 0, toggle: 1'b0, exp_step: 1, fixed: 1'b0, fixed_crc: 16'h0000};
    frames[1].w[0] = 8'hA5;
    frames[1].w[1] = 8'h3C;
    frames[1].w[2] = 8'hFF;
    // 2: "123456789" with 5 idle output cycles after word 0
    frames[2] = '{w: digits, n: 9, gap: 13, toggle: 1'b0, exp_step: 6, fixed: 1'b1, fixed_crc: 16'h29B1};
    // 3: "123456789" with in_valid toggling while in_ready is low
    frames[3] = '{w: digits, n: 9, gap: 0, toggle: 1'b1, exp_step: 1, fixed: 1'b1, fixed_crc: 16'h29B1};
    // 4: single word 0x80, last
    frames[4] = '{w: '0, n: 1, gap: 0, toggle: 1'b0, exp_step: 1, fixed: 1'b0, fixed_crc: 16'h0000};
    frames[4].w[0] = 8'h80;

    // Reset state
    #1 reset = 1'b1;
    #3;
    check("reset_outputs",
          32'({in_if.in_ready, crc_enable, crc_init, crc_data, ser_valid, ser_bit, ser_last, busy}), 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_ready_busy", 32'({in_if.in_ready, busy, ser_valid}), 32'b100);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_frame(i, frames[i]);

    // Reset during bit 4 of a word, then a clean frame must reseed
    in_if.in_data  = 8'hA5;
    in_if.in_last  = 1'b1;
    in_if.in_valid = 1'b1;
    budget = 0;
    while (!in_if.in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1 in_if.in_valid = 1'b0;
    seen   = 0;
    budget = 0;
    while (seen < 5 && budget < 50) begin
      @(negedge clk);
      if (ser_valid) seen++;
      budget++;
    end
    check("midframe_bits_before_reset", seen, 32'd5);
    #1 reset = 1'b1;
    #1;
    check("midframe_reset_outputs",
          32'({in_if.in_ready, crc_enable, crc_init, crc_data, ser_valid, ser_bit, ser_last, busy}), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'({in_if.in_ready, busy}), 32'b10);
    @(posedge clk);
    #1;
    run_frame(5, frames[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
